// File: rtl/dense_3_ctrl.sv
// Dense-layer sequencer: walks the weight ROM and input buffer, accumulates one dot product per neuron, emits results.
// Latency: NUM_IN+2 cycles per neuron, done NUM_OUT*(NUM_IN+2)+1 cycles after start; optional DENSE_SAT_EN clamps out_data.
// Backpressure: none; start is only honoured in IDLE and results are strobed once on out_valid.
module dense_3_ctrl #(
    parameter int NUM_IN     = 169,
    parameter int NUM_OUT    = 3,
    parameter int ADDR_W     = 10,
    parameter int X_ADDR_W   = 8,
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 24,
    parameter int OFFSET_ENT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                w_en,
    output logic [ADDR_W-1:0]   w_addr,
    input  logic [DATA_W-1:0]   w_data,
    output logic                x_en,
    output logic [X_ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0]   x_data,
    output logic                out_valid,
    output logic [1:0]          out_idx,
    output logic [ACC_W-1:0]    out_data
);

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, EMIT, DONE} state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DATA_W-1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(DATA_W-1)));

    state_t                     state, state_nxt;
    logic [X_ADDR_W-1:0]        i;
    logic [1:0]                 o;
    logic [ADDR_W-1:0]          base;
    logic [ADDR_W-1:0]          w_addr_q;
    logic [X_ADDR_W-1:0]        x_addr_q;
    logic                       pv;
    logic signed [ACC_W-1:0]    acc, acc_nxt, prod, x_ext, w_ext, res;
    logic                       valid_q;
    logic [1:0]                 idx_q;
    logic [ACC_W-1:0]           data_q;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        w_en      = 1'b0;
        x_en      = 1'b0;
        w_addr    = w_addr_q;
        x_addr    = x_addr_q;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy   = 1'b1;
                w_en   = 1'b1;
                x_en   = 1'b1;
                w_addr = base + ADDR_W'(i);
                x_addr = i;
                if (i == X_ADDR_W'(NUM_IN - 1)) state_nxt = FLUSH;
            end
            FLUSH: begin
                busy      = 1'b1;
                state_nxt = EMIT;
            end
            EMIT: begin
                busy      = 1'b1;
                state_nxt = (o == 2'(NUM_OUT - 1)) ? DONE : RUN;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Input is unsigned plus a signed offset; weight is signed. Product wraps into ACC_W.
    always_comb begin
        x_ext   = $signed({{(ACC_W-DATA_W){1'b0}}, x_data}) + $signed(ACC_W'(OFFSET_ENT));
        w_ext   = $signed({{(ACC_W-DATA_W){w_data[DATA_W-1]}}, w_data});
        prod    = x_ext * w_ext;
        acc_nxt = pv ? acc + prod : acc;
`ifdef DENSE_SAT_EN
        if (acc_nxt > SAT_MAX)      res = SAT_MAX;
        else if (acc_nxt < SAT_MIN) res = SAT_MIN;
        else                        res = acc_nxt;
`else
        res = acc_nxt;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            i        <= '0;
            o        <= '0;
            base     <= '0;
            acc      <= '0;
            pv       <= 1'b0;
            w_addr_q <= '0;
            x_addr_q <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            data_q   <= '0;
        end else begin
            state   <= state_nxt;
            pv      <= (state == RUN);
            acc     <= acc_nxt;
            valid_q <= (state == FLUSH);
            if (state == FLUSH) begin
                idx_q  <= o;
                data_q <= res;
            end
            case (state)
                IDLE: if (start) begin
                    i    <= '0;
                    o    <= '0;
                    base <= '0;
                    acc  <= '0;
                end
                RUN: begin
                    i        <= i + 1'b1;
                    w_addr_q <= w_addr;
                    x_addr_q <= x_addr;
                end
                EMIT: begin
                    acc  <= '0;
                    i    <= '0;
                    base <= base + ADDR_W'(NUM_IN);
                    if (o != 2'(NUM_OUT - 1)) o <= o + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_dense_3_ctrl.sv
// Bench for dense_3_ctrl: ROM/buffer models, directed and random layers checked cycle by cycle against a dot-product model.
module tb_dense_3_ctrl;
    localparam int NUM_IN  = 169;
    localparam int NUM_OUT = 3;
    localparam int PER_N   = NUM_IN + 2;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        busy, done, w_en, x_en, out_valid;
    logic [9:0]  w_addr;
    logic [7:0]  x_addr;
    logic [7:0]  w_data, x_data;
    logic [1:0]  out_idx;
    logic [23:0] out_data;

    logic [7:0] wmem [NUM_IN*NUM_OUT];
    logic [7:0] xmem [NUM_IN];

    int vectors = 0;
    int miscompares = 0;
    int hold_w = 0;
    int hold_x = 0;

    dense_3_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .x_en(x_en), .x_addr(x_addr), .x_data(x_data),
        .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_en) w_data <= wmem[w_addr];
        if (x_en) x_data <= xmem[x_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model(input int n);
        longint s = 0;
        logic [63:0] s_bits;
        logic [23:0] r;
        for (int k = 0; k < NUM_IN; k++) begin
            int xv, wv;
            xv = int'(xmem[k]);
            wv = int'($signed(wmem[n*NUM_IN + k]));
            s += longint'((xv + 1) * wv);
        end
        s_bits = s;
        r = s_bits[23:0];
`ifdef DENSE_SAT_EN
        if ($signed(r) > 24'sd127)       r = 24'd127;
        else if ($signed(r) < -24'sd128) r = 24'hFFFF80;
`endif
        return r;
    endfunction

    task automatic fill(input int mode, input logic [7:0] wv, input logic [7:0] xv);
        for (int k = 0; k < NUM_IN*NUM_OUT; k++) wmem[k] = (mode == 0) ? wv : 8'($urandom);
        for (int k = 0; k < NUM_IN; k++)         xmem[k] = (mode == 0) ? xv : 8'($urandom);
    endtask

    // Drives one layer and checks every cycle 1..515 relative to the start cycle.
    task automatic run_layer(input bit prestarted, input int abort_at, input bit repulse,
                             input bit chain, input bit use_fixed, input logic [23:0] fixed_exp);
        logic [23:0] exp_out [NUM_OUT];
        bit aborted = 1'b0;
        for (int n = 0; n < NUM_OUT; n++) exp_out[n] = use_fixed ? fixed_exp : model(n);
        if (!prestarted) start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 515; c++) begin
            int n, k;
            logic run_c, val_c, done_c, busy_c;
            n = (c - 1) / PER_N;
            k = (c - 1) % PER_N;
            run_c  = !aborted && c <= NUM_OUT*PER_N && k < NUM_IN;
            val_c  = !aborted && c <= NUM_OUT*PER_N && k == PER_N - 1;
            done_c = !aborted && c == NUM_OUT*PER_N + 1;
            busy_c = !aborted && c <= NUM_OUT*PER_N;
            if (run_c) begin
                hold_w = n*NUM_IN + k;
                hold_x = k;
            end
            check("ctl{busy,done,valid,w_en,x_en}", {27'd0, busy, done, out_valid, w_en, x_en},
                  {27'd0, busy_c, done_c, val_c, run_c, run_c});
            check("w_addr", {22'd0, w_addr}, 32'(hold_w));
            check("x_addr", {24'd0, x_addr}, 32'(hold_x));
            if (val_c) begin
                check("out_idx", {30'd0, out_idx}, 32'(n));
                check("out_data", {8'd0, out_data}, {8'd0, exp_out[n]});
            end
            start = (repulse && (c == 10 || c == 200)) || (chain && c >= 514);
            rst   = (c == abort_at);
            if (c == abort_at) begin
                aborted = 1'b1;
                hold_w  = 0;
                hold_x  = 0;
            end
            if (c < 515) @(negedge clk);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        w_data = '0;
        x_data = '0;
        fill(0, 8'd1, 8'd0);
        repeat (3) @(negedge clk);
        check("reset_outputs", {8'd0, busy, done, w_en, x_en, out_valid, out_idx, out_data[18:0]}, 32'd0);
        check("reset_data", {8'd0, out_data}, 32'd0);
        check("reset_addr", {14'd0, w_addr, x_addr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

`ifdef DENSE_SAT_EN
        run_layer(1'b0, 0, 1'b0, 1'b0, 1'b1, 24'd127);
        run_layer(1'b0, 0, 1'b1, 1'b1, 1'b1, 24'd127);
        run_layer(1'b1, 0, 1'b0, 1'b0, 1'b1, 24'd127);
        fill(0, 8'hFF, 8'd2);
        run_layer(1'b0, 0, 1'b0, 1'b0, 1'b1, 24'hFFFF80);
        fill(0, 8'h7F, 8'hFF);
        run_layer(1'b0, 0, 1'b0, 1'b0, 1'b1, 24'd127);
`else
        run_layer(1'b0, 0, 1'b0, 1'b0, 1'b1, 24'd169);
        run_layer(1'b0, 0, 1'b1, 1'b1, 1'b1, 24'd169);
        run_layer(1'b1, 0, 1'b0, 1'b0, 1'b1, 24'd169);
        fill(0, 8'hFF, 8'd2);
        run_layer(1'b0, 0, 1'b0, 1'b0, 1'b1, 24'(-507));
        fill(0, 8'h7F, 8'hFF);
        run_layer(1'b0, 0, 1'b0, 1'b0, 1'b1, 24'd5494528);
`endif

        fill(1, 8'd0, 8'd0);
        run_layer(1'b0, 250, 1'b0, 1'b0, 1'b0, 24'd0);
        run_layer(1'b0, 0, 1'b0, 1'b0, 1'b0, 24'd0);
        for (int r = 0; r < 3; r++) begin
            fill(1, 8'd0, 8'd0);
            run_layer(1'b0, 0, 1'b0, 1'b0, 1'b0, 24'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
